// File: rtl/tt_um_taghreed_eialsalman_sel_sequencer_pkg.sv
// Shared encodings for the select sequencer: operating modes and pin bit positions.
package tt_um_taghreed_eialsalman_sel_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam int unsigned UI_SEL_LSB    = 0;
  localparam int unsigned UI_STEP_BIT   = 2;
  localparam int unsigned UI_MODE_LSB   = 3;
  localparam int unsigned UI_DEC_EN_BIT = 5;
  localparam int unsigned UI_SYNC_W     = 6;

  localparam int unsigned UO_SEL_LSB    = 0;
  localparam int unsigned UO_DEC_EN_BIT = 2;
  localparam int unsigned UO_STROBE_BIT = 3;
  localparam int unsigned UO_WRAP_LSB   = 4;

  function automatic mode_e decode_mode(input logic [UI_SYNC_W-1:0] s);
    return mode_e'(s[UI_MODE_LSB +: 2]);
  endfunction

endpackage

// File: rtl/tt_um_taghreed_eialsalman_sel_sequencer_debounce.sv
// Step-button debouncer: accepts a new level after DEB_CYCLES consecutive differing samples.
module sel_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = rise_q;
    if (en) begin
      rise_d = 1'b0;
      if (din == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = din;
        rise_d  = din;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/tt_um_taghreed_eialsalman_sel_sequencer.sv
// 2-to-4 decoder select sequencer with manual, step-button, auto-scan and hold modes.
module tt_um_taghreed_eialsalman_sel_sequencer
  import tt_um_taghreed_eialsalman_sel_sequencer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DIV_W      = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [UI_SYNC_W-1:0] sync1_q, sync2_q;
  logic                 step_level, step_rise;
  mode_e                state_q, state_d, mode_sync;
  logic [1:0]           sel_q, sel_d;
  logic [3:0]           wrap_q, wrap_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 en_q, en_d;
  logic                 stb_q, stb_d;
  logic                 unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ui_in[UI_SYNC_W-1:0];
      sync2_q <= sync1_q;
    end
  end

  sel_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .din   (sync2_q[UI_STEP_BIT]),
    .level (step_level),
    .rise  (step_rise)
  );

  // Behaviour is chosen by state_q, so a mode change landing on a step edge
  // or divider tick is resolved in the mode that was active before it.
  always_comb begin
    mode_sync = decode_mode(sync2_q);
    state_d   = state_q;
    sel_d     = sel_q;
    wrap_d    = wrap_q;
    div_d     = div_q;
    en_d      = en_q;
    stb_d     = 1'b0;
    if (ena) begin
      state_d = mode_sync;
      en_d    = sync2_q[UI_DEC_EN_BIT];
      case (state_q)
        MODE_MANUAL: sel_d = sync2_q[UI_SEL_LSB +: 2];
        MODE_STEP: begin
          if (step_rise) sel_d = sel_q + 2'd1;
        end
        MODE_AUTO: begin
          if (div_q == '0) begin
            sel_d = sel_q + 2'd1;
            div_d = uio_in[DIV_W-1:0];
          end else begin
            div_d = div_q - 1'b1;
          end
        end
        default: ;
      endcase
      if (state_q != MODE_AUTO && mode_sync == MODE_AUTO) div_d = uio_in[DIV_W-1:0];
      if ((state_q == MODE_STEP || state_q == MODE_AUTO) && sel_q == 2'd3 && sel_d == 2'd0)
        wrap_d = wrap_q + 4'd1;
      stb_d = (sel_d != sel_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MODE_MANUAL;
      sel_q   <= '0;
      wrap_q  <= '0;
      div_q   <= '0;
      en_q    <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
      div_q   <= div_d;
      en_q    <= en_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    uo_out                    = '0;
    uo_out[UO_SEL_LSB +: 2]   = sel_q;
    uo_out[UO_DEC_EN_BIT]     = en_q;
    uo_out[UO_STROBE_BIT]     = stb_q;
    uo_out[UO_WRAP_LSB +: 4]  = wrap_q;
  end

  assign uio_out     = '0;
  assign uio_oe      = '0;
  assign unused_bits = &{1'b0, ui_in[7:6], uio_in, step_level};

endmodule
